// File: rtl/seq_display_ctrl.sv
// seq_display_ctrl
// ----------------
// Sequential-entry display controller. Each debounced press of the load key
// captures the 4-bit switch value into digit 0 and moves every stored digit
// up one position. Each digit position drives one active-low 7-segment
// pattern. A prescaler tick enable paces the key sampling, so the whole
// block runs on a single clock.
//
// Optional feature (compile-time macro SEQ_DISPLAY_CTRL_BLINK_EN):
//   When the macro is defined, a full buffer blinks. The display goes blank
//   on every other tick while the state is FULL. When the macro is not
//   defined, a full buffer is shown steadily.
//
// Parameters:
//   DIGITS : number of digit positions and buffer depth (1..8)
//   DIV    : clock cycles per tick (>= 2)
//
// Ports:
//   clock : single clock; all state changes on its rising edge
//   reset : synchronous, active-high
//   data  : 4-bit value to capture
//   load  : load key, level, active-high; sampled only on tick cycles
//   clear : synchronous buffer clear, active-high; has priority over capture
//   segs  : 7*DIGITS segment outputs; digit i is segs[7i+6:7i], bits g..a,
//           active-low
//   cnt   : number of stored entries
//   full  : high when cnt == DIGITS
//
// Handshake: none. load is a level input. A capture occurs on a tick edge
// when load is 1 and the value sampled on the previous tick was 0.

module seq_display_ctrl #(
  parameter int DIGITS = 6,
  parameter int DIV    = 50_000_000,
  localparam int CNT_W = $clog2(DIGITS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            data,
  input  logic                  load,
  input  logic                  clear,
  output logic [7*DIGITS-1:0]   segs,
  output logic [CNT_W-1:0]      cnt,
  output logic                  full
);

  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q;
  logic             load_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       digit_q [DIGITS];
  logic             tick;
  logic             capture;
  logic             shift;

  // Hex decode, bits g..a, active-low; covers the full 0-F set.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick    = (pre_q == PRE_W'(DIV - 1));
  // Rising-edge detect on the tick-sampled key: a held key captures once.
  assign capture = tick && load && !load_q;

  // The prescaler and the key sample are not affected by clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q  <= '0;
      load_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) load_q <= load;
    end
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. clear beats capture, and a capture while full is
  // dropped. With DIGITS=1 the first capture goes straight to FULL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift   = 1'b0;
    if (clear) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (capture && (state_q != FULL)) begin
      shift   = 1'b1;
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = (cnt_q == CNT_W'(DIGITS - 1)) ? FULL : FILLING;
    end
  end

  // Digit buffer: digit i+1 takes digit i, and digit 0 takes data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'h0;
    end else if (shift) begin
      for (int i = DIGITS - 1; i > 0; i--) digit_q[i] <= digit_q[i-1];
      digit_q[0] <= data;
    end
  end

`ifdef SEQ_DISPLAY_CTRL_BLINK_EN
  logic phase_q;

  // Held at 0 outside FULL, so the first FULL cycle shows the digits.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= 1'b0;
    end else if (state_q != FULL) begin
      phase_q <= 1'b0;
    end else if (tick) begin
      phase_q <= ~phase_q;
    end
  end
`endif

  // Only positions that hold an entry are lit. All other positions are blank.
  always_comb begin
    segs = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (CNT_W'(i) < cnt_q) segs[7*i +: 7] = hex7(digit_q[i]);
    end
`ifdef SEQ_DISPLAY_CTRL_BLINK_EN
    if (phase_q) segs = '1;
`endif
  end

  assign cnt  = cnt_q;
  assign full = (state_q == FULL);

endmodule

// File: tb/tb_seq_display_ctrl.sv
// Testbench for seq_display_ctrl with DIGITS=6 and DIV=4.
// A reference model follows the key, tick and clear rules using a queue of
// stored nibbles (newest first) and a cycle count since reset. Every cycle,
// the DUT outputs are compared with the model.

module tb_seq_display_ctrl;

  localparam int DIGITS = 6;
  localparam int DIV    = 4;
  localparam int CNT_W  = $clog2(DIGITS + 1);
  localparam int SW     = 7 * DIGITS;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       data  = 4'h0;
  logic             load  = 1'b0;
  logic             clear = 1'b0;
  logic [SW-1:0]    segs;
  logic [CNT_W-1:0] cnt;
  logic             full;

  always #5 clock = ~clock;

  seq_display_ctrl #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clock (clock),
    .reset (reset),
    .data  (data),
    .load  (load),
    .clear (clear),
    .segs  (segs),
    .cnt   (cnt),
    .full  (full)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [3:0] exp_q[$];   // stored entries, exp_q[0] is digit 0
  int         m_cyc;      // cycles since the last reset edge
  bit         m_key_prev; // key level seen at the previous tick
  bit         m_phase;    // blink phase (stays 0 when blink is not built)

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] exp_segs();
    logic [SW-1:0] r;
    r = '1;
    for (int i = 0; i < exp_q.size(); i++) r[7*i +: 7] = HEX[exp_q[i]];
    if (m_phase) r = '1;
    return r;
  endfunction

  // Applies one clock edge to the model, using the inputs seen at that edge.
  task automatic model_edge(input logic [3:0] d, input logic l, input logic c, input logic r);
    bit tick, cap, was_full;
    if (r) begin
      exp_q.delete();
      m_cyc      = 0;
      m_key_prev = 0;
      m_phase    = 0;
      return;
    end
    tick     = ((m_cyc % DIV) == DIV - 1);
    cap      = tick && l && !m_key_prev;
    was_full = (exp_q.size() == DIGITS);
    if (tick) m_key_prev = l;
`ifdef SEQ_DISPLAY_CTRL_BLINK_EN
    if (!was_full) m_phase = 0;
    else if (tick) m_phase = !m_phase;
`endif
    if (c) exp_q.delete();
    else if (cap && exp_q.size() < DIGITS) exp_q.push_front(d);
    m_cyc++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] d, input logic l, input logic c, input logic r);
    data  = d;
    load  = l;
    clear = c;
    reset = r;
    model_edge(d, l, c, r);
    @(posedge clock);
    #1;
    check("cnt",  64'(cnt),  64'(exp_q.size()));
    check("full", 64'(full), 64'(exp_q.size() == DIGITS));
    check("segs", 64'(segs), 64'(exp_segs()));
  endtask

  // The press and the release each span a tick, so each pair captures once.
  task automatic press(input logic [3:0] d);
    repeat (DIV) step(d, 1'b1, 1'b0, 1'b0);
    repeat (DIV) step(d, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic l;

    // Reset followed by 20 idle cycles
    step(4'h0, 1'b0, 1'b0, 1'b1);
    check("rst_cnt",  64'(cnt),  64'd0);
    check("rst_segs", 64'(segs), {{(64-SW){1'b0}}, {SW{1'b1}}});
    repeat (20) step(4'h0, 1'b0, 1'b0, 1'b0);

    // A held key captures exactly once
    repeat (12) step(4'h3, 1'b1, 1'b0, 1'b0);
    check("hold_cnt",  64'(cnt),        64'd1);
    check("hold_dig0", 64'(segs[6:0]),  64'(7'b0110000));
    check("hold_hi",   64'(segs[SW-1:7]), 64'({(SW-7){1'b1}}));
    repeat (DIV) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Fill with 1..6, then a seventh press is ignored
    step(4'h0, 1'b0, 1'b1, 1'b0);
    for (int v = 1; v <= 6; v++) press(4'(v));
    press(4'h9);
    check("fill_cnt",  64'(cnt),  64'd6);
    check("fill_full", 64'(full), 64'd1);
`ifndef SEQ_DISPLAY_CTRL_BLINK_EN
    check("fill_dig0", 64'(segs[6:0]),   64'(7'b0000010));
    check("fill_dig5", 64'(segs[41:35]), 64'(7'b1111001));
`endif

    // A clear that coincides with a capturing tick wins
    step(4'h0, 1'b0, 1'b1, 1'b0);
    press(4'h1);
    press(4'h2);
    for (int k = 0; k < DIV && (m_cyc % DIV) != DIV - 1; k++) step(4'h0, 1'b0, 1'b0, 1'b0);
    step(4'h7, 1'b1, 1'b1, 1'b0);
    check("clr_cnt",  64'(cnt),  64'd0);
    check("clr_full", 64'(full), 64'd0);
    check("clr_segs", 64'(segs), {{(64-SW){1'b0}}, {SW{1'b1}}});
    repeat (DIV) step(4'h0, 1'b0, 1'b0, 1'b0);

    // A full buffer stays full for 40 cycles (blink behaviour is modelled)
    for (int v = 0; v < DIGITS; v++) press(4'($urandom_range(0, 15)));
    repeat (40) step(4'h0, 1'b0, 1'b0, 1'b0);

    // Reset aborts a fill; with load held, the first capture is on edge 4
    step(4'h0, 1'b0, 1'b1, 1'b0);
    repeat (3) press(4'($urandom_range(0, 15)));
    step(4'h5, 1'b1, 1'b0, 1'b1);
    check("rst2_cnt",  64'(cnt),  64'd0);
    check("rst2_segs", 64'(segs), {{(64-SW){1'b0}}, {SW{1'b1}}});
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'h5, 1'b1, 1'b0, 1'b0);
      n++;
      if (cnt == CNT_W'(1)) break;
    end
    check("rst2_latency", 64'(n), 64'd4);

    // Random traffic
    l = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0) l = ~l;
      step(4'($urandom_range(0, 15)), l,
           ($urandom_range(0, 59) == 0), ($urandom_range(0, 249) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
